// File: rtl/serial_adder.sv
// serial_adder: bit-serial WIDTH-bit adder, one full-adder slice plus a carry flip-flop, LSB first
module full_adder (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic s_o,
    output logic co_o
);
    assign s_o  = a_i ^ b_i ^ c_i;
    assign co_o = (a_i & b_i) | (c_i & (a_i ^ b_i));
endmodule

module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset_b,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             c_in,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             busy,
    output logic             done
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH);
    localparam logic [CW-1:0] ONE = CW'(1);
    typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;
    state_t state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic carry_q, carry_d;
    logic [CW-1:0] count_q, count_d;
    logic s, co;
    full_adder u_fa (
        .a_i (a_q[0]),
        .b_i (b_q[0]),
        .c_i (carry_q),
        .s_o (s),
        .co_o(co)
    );
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        count_d = count_q;
        case (state_q)
            IDLE: if (start) begin
                a_d     = a_in;
                b_d     = b_in;
                carry_d = c_in;
                count_d = CNT_INIT;
                state_d = ADD;
            end
            ADD: begin
                a_d     = {s, a_q[WIDTH-1:1]};
                b_d     = {1'b0, b_q[WIDTH-1:1]};
                carry_d = co;
                count_d = count_q - ONE;
                state_d = (count_q == ONE) ? DONE : ADD;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clock) begin
        if (!reset_b) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            count_q <= count_d;
        end
    end
    assign sum   = a_q;
    assign c_out = carry_q;
    assign busy  = (state_q == ADD);
    assign done  = (state_q == DONE);
endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: directed and held-start checks of the bit-serial adder at WIDTH=8
module tb_serial_adder;
    logic       clock = 1'b0;
    logic       reset_b, start, c_in;
    logic [7:0] a_in, b_in, sum;
    logic       c_out, busy, done;
    int         total = 0;
    int         bad = 0;

    serial_adder #(.WIDTH(8)) dut (
        .clock  (clock),
        .reset_b(reset_b),
        .start  (start),
        .a_in   (a_in),
        .b_in   (b_in),
        .c_in   (c_in),
        .sum    (sum),
        .c_out  (c_out),
        .busy   (busy),
        .done   (done)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called at a negedge with the DUT idle; returns at the negedge of the following idle cycle.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic c,
                          input logic [7:0] es, input logic ec, input int inj);
        start = 1'b1; a_in = a; b_in = b; c_in = c;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clock);
            if (i == 1) begin start = 1'b0; a_in = ~a; b_in = ~b; c_in = ~c; end
            if (i == inj) begin start = 1'b1; a_in = 8'hAA; b_in = 8'h55; c_in = 1'b1; end
            if (i == inj + 1) start = 1'b0;
            chk("busy", busy, 1);
            chk("done_early", done, 0);
        end
        @(negedge clock);
        chk("done", done, 1);
        chk("busy_off", busy, 0);
        chk("sum", sum, es);
        chk("c_out", c_out, ec);
        @(negedge clock);
        chk("done_pulse_end", done, 0);
        chk("sum_held", sum, es);
        chk("c_out_held", c_out, ec);
    endtask

    initial begin
        logic [8:0] ref_res;
        reset_b = 1'b0; start = 1'b0; a_in = 8'h00; b_in = 8'h00; c_in = 1'b0;
        @(negedge clock);
        @(negedge clock);
        chk("rst_sum", sum, 0);
        chk("rst_cout", c_out, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        reset_b = 1'b1;
        @(negedge clock);

        run_op(8'h3C, 8'h25, 1'b0, 8'h61, 1'b0, 0);
        run_op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 0);
        run_op(8'h7F, 8'h80, 1'b1, 8'h00, 1'b1, 0);
        run_op(8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 4);

        // Abort with reset during ADD cycle 5; the operation must never complete.
        start = 1'b1; a_in = 8'hF0; b_in = 8'h0F; c_in = 1'b0;
        @(negedge clock);
        start = 1'b0;
        repeat (4) @(negedge clock);
        reset_b = 1'b0;
        @(negedge clock);
        reset_b = 1'b1;
        chk("abort_sum", sum, 0);
        chk("abort_cout", c_out, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        for (int i = 0; i < 12; i++) begin
            @(negedge clock);
            chk("abort_no_done", done, 0);
            chk("abort_idle", busy, 0);
        end

        // Start held high: one acceptance every 10 cycles, operands churn in between.
        start = 1'b1;
        for (int n = 0; n < 256; n++) begin
            a_in = 8'($urandom); b_in = 8'($urandom); c_in = 1'($urandom);
            ref_res = {1'b0, a_in} + {1'b0, b_in} + {8'h00, c_in};
            chk("b2b_idle_done", done, 0);
            for (int i = 1; i <= 9; i++) begin
                @(negedge clock);
                a_in = 8'($urandom); b_in = 8'($urandom); c_in = 1'($urandom);
                if (i < 9) chk("b2b_done_early", done, 0);
            end
            chk("b2b_done", done, 1);
            chk("b2b_sum", sum, ref_res[7:0]);
            chk("b2b_cout", c_out, ref_res[8]);
            @(negedge clock);
        end
        start = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
